// File: rtl/shift_rows_pipe_pkg.sv
// aes_pkg: shared AES/Rijndael constants and helpers for the round pipeline stages.
`default_nettype none

package aes_pkg;

  localparam int NB_MIN      = 4;
  localparam int NB_MID      = 6;
  localparam int NB_MAX      = 8;
  localparam int TAG_INV_BIT = 0;

  function automatic bit nb_is_legal(input int nb);
    return (nb == NB_MIN) || (nb == NB_MID) || (nb == NB_MAX);
  endfunction

  // Rijndael uses a wider row-3/row-4 spread only for 256-bit blocks
  function automatic int shr_offset(input int nb, input int row);
    int off;
    off = row;
    if (nb == NB_MAX) begin
      case (row)
        2:       off = 3;
        3:       off = 4;
        default: off = row;
      endcase
    end
    return off;
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_rows_pipe_skid_fifo2.sv
// skid_fifo2: 2-entry valid/ready buffer; ready depends on registered occupancy only.
`default_nettype none

module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign busy      = (count != 2'd0);
  assign out_data  = mem[head];

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      // Storage keeps stale contents; only occupancy is dropped
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: ShiftRows stage with valid/ready skid buffer.
// Optional InvShiftRows per block via In_Tag[0] when SHR_INV_EN is defined.
`default_nettype none

module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB         = 4,
  parameter int MODE_TAG_W = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Flush,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [32*NB-1:0]      In_Data,
  input  logic [MODE_TAG_W-1:0] In_Tag,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [32*NB-1:0]      Out_Data,
  output logic [MODE_TAG_W-1:0] Out_Tag,
  output logic                  Busy
);

  localparam int W = 32 * NB;

  logic [W-1:0]            fwd;
  logic [W-1:0]            shifted;
  logic [W+MODE_TAG_W-1:0] fifo_in;
  logic [W+MODE_TAG_W-1:0] fifo_out;

  // Byte k sits at the MSB end: k = 4*col + row
  for (genvar k = 0; k < 4 * NB; k++) begin : g_fwd_byte
    localparam int ROW = k % 4;
    localparam int COL = k / 4;
    localparam int SRC = byte_idx(ROW, (COL + shr_offset(NB, ROW)) % NB);
    assign fwd[W-1-8*k -: 8] = In_Data[W-1-8*SRC -: 8];
  end

`ifdef SHR_INV_EN
  logic [W-1:0] inv;

  for (genvar k = 0; k < 4 * NB; k++) begin : g_inv_byte
    localparam int ROW = k % 4;
    localparam int COL = k / 4;
    localparam int SRC = byte_idx(ROW, (COL - shr_offset(NB, ROW) + NB) % NB);
    assign inv[W-1-8*k -: 8] = In_Data[W-1-8*SRC -: 8];
  end

  assign shifted = In_Tag[TAG_INV_BIT] ? inv : fwd;
`else
  assign shifted = fwd;
`endif

  assign fifo_in = {shifted, In_Tag};

  skid_fifo2 #(
    .WIDTH(W + MODE_TAG_W)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .flush    (Flush),
    .in_valid (In_Valid),
    .in_ready (In_Ready),
    .in_data  (fifo_in),
    .out_valid(Out_Valid),
    .out_ready(Out_Ready),
    .out_data (fifo_out),
    .busy     (Busy)
  );

  assign Out_Data = fifo_out[W+MODE_TAG_W-1:MODE_TAG_W];
  assign Out_Tag  = fifo_out[MODE_TAG_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: queue-based reference model plus directed literal vectors.
`default_nettype none

module tb_shift_rows_pipe;

  localparam int TW = 4;

  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic           Flush = 1'b0;
  logic           In_Valid = 1'b0;
  logic           In_Ready;
  logic [127:0]   In_Data = '0;
  logic [TW-1:0]  In_Tag = '0;
  logic           Out_Valid;
  logic           Out_Ready;
  logic [127:0]   Out_Data;
  logic [TW-1:0]  Out_Tag;
  logic           Busy;

  logic           rand_mode = 1'b0;
  logic           fix_rdy = 1'b1;
  logic           rnd_rdy = 1'b1;
  assign Out_Ready = rand_mode ? rnd_rdy : fix_rdy;

  logic           In_Valid8 = 1'b0;
  logic           In_Ready8;
  logic [255:0]   In_Data8 = '0;
  logic [0:0]     In_Tag8 = '0;
  logic           Out_Valid8;
  logic [255:0]   Out_Data8;
  logic [0:0]     Out_Tag8;
  logic           Busy8;

  int total = 0;
  int bad = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [127+TW:0] q[$];

  shift_rows_pipe #(.NB(4), .MODE_TAG_W(TW)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data), .In_Tag(In_Tag),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_Tag(Out_Tag),
    .Busy(Busy)
  );

  shift_rows_pipe #(.NB(8), .MODE_TAG_W(1)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(1'b0),
    .In_Valid(In_Valid8), .In_Ready(In_Ready8), .In_Data(In_Data8), .In_Tag(In_Tag8),
    .Out_Valid(Out_Valid8), .Out_Ready(1'b1), .Out_Data(Out_Data8), .Out_Tag(Out_Tag8),
    .Busy(Busy8)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // State viewed as a 4 x nb byte matrix; each row rotated by its offset
  function automatic logic [255:0] model(input logic [255:0] din, input int nb, input bit inv_req);
    logic [7:0]   b [32];
    logic [255:0] res;
    int           off [4];
    bit           inv;
    int           src;
    res = '0;
    `ifdef SHR_INV_EN
    inv = inv_req;
    `else
    inv = 1'b0;
    `endif
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    for (int k = 0; k < 4 * nb; k++) b[k] = din[nb*32-1-8*k -: 8];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        res[nb*32-1-8*(4*c+r) -: 8] = b[4*src+r];
      end
    end
    return res;
  endfunction

  // Reference update happens mid-cycle, between input changes and the next edge
  always @(negedge Clk) begin
    bit push, pop;
    if (!Rst_n) begin
      chk("rst_out_valid", {255'd0, Out_Valid}, 256'd0);
      chk("rst_busy", {255'd0, Busy}, 256'd0);
      chk("rst_out_data", {128'd0, Out_Data}, 256'd0);
      chk("rst_out_tag", {252'd0, Out_Tag}, 256'd0);
      q.delete();
    end else begin
      chk("in_ready", {255'd0, In_Ready}, {255'd0, q.size() < 2});
      chk("out_valid", {255'd0, Out_Valid}, {255'd0, q.size() > 0});
      chk("busy", {255'd0, Busy}, {255'd0, q.size() != 0});
      if (q.size() > 0) begin
        chk("out_data", {128'd0, Out_Data}, {128'd0, q[0][127+TW:TW]});
        chk("out_tag", {252'd0, Out_Tag}, {252'd0, q[0][TW-1:0]});
      end
      if (Flush) begin
        q.delete();
      end else begin
        pop  = (q.size() > 0) && Out_Ready;
        push = In_Valid && (q.size() < 2);
        if (pop) begin
          void'(q.pop_front());
          n_pop++;
        end
        if (push) begin
          q.push_back({model({128'd0, In_Data}, 4, In_Tag[0])[127:0], In_Tag});
          n_push++;
        end
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input logic [127:0] d, input logic [TW-1:0] t);
    bit rdy;
    In_Valid = 1'b1;
    In_Data  = d;
    In_Tag   = t;
    for (int i = 0; i < 500; i++) begin
      rdy = In_Ready;
      @(posedge Clk); #1;
      if (rdy) return;
    end
    chk("send_timeout", 256'd1, 256'd0);
  endtask

  task automatic drain();
    In_Valid = 1'b0;
    for (int i = 0; i < 500 && q.size() != 0; i++) begin
      @(posedge Clk); #1;
    end
    chk("drain", {224'd0, 32'(q.size())}, 256'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, c;
    logic [255:0] v8;
    repeat (3) @(posedge Clk);
    #2 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("ready_after_reset", {255'd0, In_Ready}, 256'd1);

    // forward NB=4 literal
    send(128'h00112233445566778899aabbccddeeff, 4'h0);
    In_Valid = 1'b0;
    chk("fwd_lit_valid", {255'd0, Out_Valid}, 256'd1);
    chk("fwd_lit_data", {128'd0, Out_Data}, {128'd0, 128'h0055aaff4499ee3388dd2277cc1166bb});
    @(posedge Clk); #1;

    // inverse request literal
    send(128'h0055aaff4499ee3388dd2277cc1166bb, 4'h1);
    In_Valid = 1'b0;
    `ifdef SHR_INV_EN
    chk("inv_lit_data", {128'd0, Out_Data}, {128'd0, 128'h00112233445566778899aabbccddeeff});
    `else
    chk("inv_lit_data", {128'd0, Out_Data}, {128'd0, 128'h009922bb44dd66ff8811aa33cc55ee77});
    `endif
    chk("inv_lit_tag", {252'd0, Out_Tag}, 256'd1);
    @(posedge Clk); #1;

    // backpressure: two accepted, third held
    a = 128'h0f0e0d0c0b0a09080706050403020100;
    b = 128'hdeadbeef0123456789abcdeffedcba98;
    c = 128'h11111111222222223333333344444444;
    fix_rdy = 1'b0;
    send(a, 4'h2);
    send(b, 4'h5);
    chk("bp_full_ready", {255'd0, In_Ready}, 256'd0);
    In_Valid = 1'b1; In_Data = c; In_Tag = 4'h8;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("bp_hold_ready", {255'd0, In_Ready}, 256'd0);
      chk("bp_stable_data", {128'd0, Out_Data}, {128'd0, 128'h0f0a05000b06010c07020d08030e0904});
      chk("bp_stable_tag", {252'd0, Out_Tag}, 256'd2);
    end
    fix_rdy = 1'b1;
    send(c, 4'h8);
    drain();

    // random backpressure stream
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, TW'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) begin
        In_Valid = 1'b0;
        @(posedge Clk); #1;
      end
    end
    drain();
    rand_mode = 1'b0;
    chk("stream_count", {224'd0, 32'(n_pop)}, {224'd0, 32'(n_push)});

    // NB=8 forward
    for (int k = 0; k < 32; k++) v8[255-8*k -: 8] = 8'(k);
    In_Data8 = v8; In_Tag8 = 1'b0; In_Valid8 = 1'b1;
    @(posedge Clk); #1;
    In_Valid8 = 1'b0;
    chk("nb8_valid", {255'd0, Out_Valid8}, 256'd1);
    chk("nb8_r2c0", {248'd0, Out_Data8[255-8*2 -: 8]}, 256'h0e);
    chk("nb8_r3c0", {248'd0, Out_Data8[255-8*3 -: 8]}, 256'h13);
    chk("nb8_r1c7", {248'd0, Out_Data8[255-8*29 -: 8]}, 256'h01);
    chk("nb8_full", Out_Data8, model(v8, 8, 1'b0));

    // flush at count=2 with push offered
    fix_rdy = 1'b0;
    send(a, 4'h3);
    send(b, 4'h4);
    In_Valid = 1'b1; In_Data = c; Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush2_valid", {255'd0, Out_Valid}, 256'd0);
    chk("flush2_busy", {255'd0, Busy}, 256'd0);
    // flush at count=1 discards the same-cycle push
    send(a, 4'h6);
    In_Valid = 1'b1; In_Data = b; Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush1_valid", {255'd0, Out_Valid}, 256'd0);
    chk("flush1_busy", {255'd0, Busy}, 256'd0);

    // asynchronous reset mid-stream
    send(a, 4'h7);
    send(b, 4'h9);
    In_Valid = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_valid", {255'd0, Out_Valid}, 256'd0);
    chk("arst_busy", {255'd0, Busy}, 256'd0);
    chk("arst_data", {128'd0, Out_Data}, 256'd0);
    @(posedge Clk); #2 Rst_n = 1'b1;
    fix_rdy = 1'b1;
    @(posedge Clk); #1;
    chk("arst_ready_after", {255'd0, In_Ready}, 256'd1);
    send(c, 4'hf);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised AES/Rijndael ShiftRows stage with an optional inverse mode (InvShiftRows) for the decrypt path.
- Supports Rijndael block widths of 4, 6 or 8 columns.
- Replaces the single-shot enable/ready scheme with a valid/ready stream interface and a 2-entry skid buffer, so the round pipeline can stall without dropping data.
- Sits between SubBytes and MixColumns in the round datapath, one block per cycle when unstalled.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8; state width W = 32*NB.
- MODE_TAG_W, 1, width of the sideband tag carried alongside each block (bit 0 = inverse request).

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Flush  input  1  synchronous clear of buffered blocks
- In_Valid  input  1  input block valid
- In_Ready  output  1  block accepted when In_Valid & In_Ready at posedge
- In_Data  input  W  state, column-major; byte k at [W-1-8k : W-8-8k]; byte k = row k%4, column k/4
- In_Tag  input  MODE_TAG_W  sideband; bit 0 = 1 selects inverse
- Out_Valid  output  1  output block valid
- Out_Ready  input  1  downstream accepts when Out_Valid & Out_Ready
- Out_Data  output  W  shifted state
- Out_Tag  output  MODE_TAG_W  In_Tag echoed with its block
- Busy  output  1  high while any block is buffered

Behaviour:
- Asynchronous reset (Rst_n low): buffer count = 0, Out_Valid = 0, Out_Data = 0, Out_Tag = 0, Busy = 0. In_Ready is 1 from the first edge after release.
- Row shift offsets:
  - NB=4 and NB=6: {0,1,2,3}.
  - NB=8: {0,1,3,4}.
- Forward transform: out(r,c) = in(r, (c + s_r) mod NB).
- Inverse transform (Tag[0]=1): out(r,c) = in(r, (c - s_r + NB) mod NB).
- The transform is combinational on the input side. The result is written into the buffer at acceptance.
- Latency: block accepted at edge k appears on Out_Data with Out_Valid=1 after edge k (one cycle).
- Throughput is 1 block/cycle while Out_Ready is held high.
- Buffer is a 2-entry FIFO (head/tail pointer, count 0..2):
  - In_Ready = (count < 2). This is combinational from registered state only, with no path from Out_Ready.
  - Out_Valid = (count > 0). Out_Data/Out_Tag show the head entry and are stable while Out_Valid & !Out_Ready.
  - Push and pop in the same cycle: count unchanged and ordering preserved. At count=2 no push is possible, so a pop alone gives count=1.
  - Pop with count=0 cannot occur (Out_Valid=0). In_Valid while In_Ready=0 is ignored and the block is not captured.
- Flush: at the next edge, count=0, Out_Valid=0, and any same-cycle push is discarded. Flush has priority over push and pop. Data registers are not cleared.
- Busy = (count != 0).
- Reset asserted mid-stream: all buffered blocks are lost immediately, asynchronously.
- Out_Tag bits above bit 0 pass through untouched, for round index or key-slot tagging.

Optional Feature:
- Macro: SHR_INV_EN.
- Defined: inverse mode is selected per block by In_Tag[0], as above.
- Undefined: In_Tag[0] is ignored for the transform (forward only), the inverse mux is not built, and Out_Tag still echoes In_Tag unchanged.

Decomposition:
- Shared package aes_pkg holds:
  - NB legality constants and the shift-offset function shr_offset(nb, row).
  - State byte-index helper byte_idx(row, col) = 4*col + row.
  - Tag bit position constant TAG_INV_BIT = 0.
- One natural sub-module, skid_fifo2: a 2-entry valid/ready buffer of width W+MODE_TAG_W, reusable by SubBytes and MixColumns stages.
- The transform stays in the top as a generate loop.

Test Plan:
- Forward, NB=4, In_Data=00112233445566778899aabbccddeeff, Tag=0, Out_Ready=1 -> one cycle later Out_Data=0055aaff4499ee3388dd2277cc1166bb, Out_Valid=1.
- Inverse (SHR_INV_EN), NB=4, In_Data=0055aaff4499ee3388dd2277cc1166bb, Tag=1 -> Out_Data=00112233445566778899aabbccddeeff. Without the macro, the same stimulus gives a forward shift.
- Backpressure: Out_Ready=0 while 3 blocks are offered:
  - First two accepted, In_Ready=0 after the second; third held by the source.
  - Out_Data stable.
  - Raise Out_Ready -> blocks emerge in order A, B, C with no loss or duplication.
- Streaming with random Out_Ready over 1000 blocks, mixed tags -> output matches a reference model in order, and Out_Tag matches each block.
- NB=8, bytes 00..1f sequential, forward -> out(2,0)=in(2,3)=0e, out(3,0)=in(3,4)=13, out(1,7)=in(1,0)=01.
- Flush with count=2 and simultaneous push -> next cycle Out_Valid=0, Busy=0. Separately, Rst_n pulse mid-stream -> outputs clear immediately without waiting for Clk.
